// File: rtl/gray_seq_checker.sv
// gray_seq_checker: converts a Gray counter's output to binary and checks each sample
// against the expected successor, flagging errors, wraps and sticky faults.
module gray_seq_checker #(
    parameter int WIDTH       = 5,
    parameter int ERR_W       = 8,
    parameter int FAULT_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clear,
    output logic [WIDTH-1:0] bin_out,
    output logic             error,
    output logic             wrap,
    output logic             locked,
    output logic             fault,
    output logic [ERR_W-1:0] err_count
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;
    logic [1:0]       state;
    logic [WIDTH-1:0] bin_now, prev_bin, exp_bin;
    logic [3:0]       consec;
    logic             en_q, mismatch;
    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        bin_now = '0;
        for (int i = 0; i < WIDTH; i++) bin_now[i] = ^(gray_in >> i);
    end
    assign exp_bin  = en_q ? prev_bin + 1'b1 : prev_bin;
    assign mismatch = bin_now != exp_bin;
    assign locked   = state == TRACK;
    assign fault    = state == FAULT;
    // The reference is always reloaded, so a single glitch resynchronises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prev_bin  <= '0;
            en_q      <= 1'b0;
            consec    <= '0;
            bin_out   <= '0;
            error     <= 1'b0;
            wrap      <= 1'b0;
            err_count <= '0;
        end else begin
            bin_out  <= bin_now;
            prev_bin <= bin_now;
            en_q     <= enable;
            error    <= 1'b0;
            wrap     <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                err_count <= '0;
                consec    <= '0;
            end else if (state == IDLE) begin
                state <= TRACK;
            end else if (state == TRACK) begin
                error  <= mismatch;
                wrap   <= en_q && (&prev_bin) && bin_now == '0;
                consec <= mismatch ? consec + 4'd1 : 4'd0;
                if (mismatch && err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
                if (mismatch && consec + 4'd1 == 4'(FAULT_LIMIT)) state <= FAULT;
            end
        end
    end
endmodule
